controlador_multiciclo: RTL
===========================

# controlador_multiciclo

Parametrised multicycle MIPS control unit, next generation of the current controller FSM. Drives the multicycle datapath (PC, IR, A/B, ULASaida and MDR registers, register file, ALU muxes, unified memory). Adds a configurable memory wait-state counter in place of hard-coded wait states. Adds `addi`, `bne` and `j`, resolves branches internally from the ALU Zero flag, and flags illegal opcodes.

## Interface
- `MEM_WAIT`, 2: memory read latency in extra cycles, 0..15. Address is held for MEM_WAIT+1 cycles before data is captured.
- `Clock`  in  1  single clock; all state updates on the rising edge.
- `Reset`  in  1  synchronous, active-high. Forces state FETCH.
- `OpCode`  in  6  IR[31:26].
- `Funct`  in  6  IR[5:0].
- `Zero`  in  1  ALU zero flag, combinational from the datapath.
- `PCEsc`  out  1  PC write enable; branch condition already folded in.
- `FontePC`  out  2  PC source: 00 ALU result, 01 ULASaida, 10 jump target.
- `CtrMem`  out  1  1 = memory write, 0 = read.
- `IouD`  out  1  memory address: 0 PC, 1 ULASaida.
- `IREsc`, `MDRCtrl`, `RegACtrl`, `RegBCtrl`, `ULASaidaCtrl`  out  1 each  register load enables.
- `RegWrite`  out  1  register file write.
- `RegDst`  out  1  destination register: 0 rt, 1 rd.
- `MemParaReg`  out  1  write-back data: 0 ULASaida, 1 MDR.
- `ULAFonteA`  out  1  ALU A input: 0 PC, 1 A.
- `ULAFonteB`  out  2  ALU B input: 00 B, 01 const 4, 10 signext(imm), 11 signext(imm)<<2.
- `ULAOp`  out  2  00 add, 01 sub, 10 by funct, 11 don't-care/idle.
- `IllegalOp`  out  1  one-cycle pulse in DECODE for an unsupported opcode.
- `Halted`  out  1  high while in HALT.
- `state`  out  6  current state code, for debug.

## Operation
- The Moore FSM has its own state register and a 4-bit wait counter `wcnt`.
- All outputs decode from `state` only; `PCEsc` in BRANCH also depends on `Zero` and the latched branch type.
- Any signal not listed for a state is 0, except `ULAOp`, which is 11.
- FETCH (0):
  - Controls: IouD=0, CtrMem=0.
  - On entry wcnt=MEM_WAIT. Stay while wcnt≠0, decrementing each cycle. At wcnt=0 go to IR_LOAD.
- IR_LOAD (1):
  - Controls: IREsc=1, PCEsc=1, FontePC=00, ULAFonteA=0, ULAFonteB=01, ULAOp=00. PC ← PC+4.
  - Next: DECODE.
- DECODE (2):
  - Controls: RegACtrl=RegBCtrl=1, ULAFonteA=0, ULAFonteB=11, ULAOp=00, ULASaidaCtrl=1 (branch target into ULASaida).
  - Dispatch on OpCode:
    - 000000 with Funct 001101: HALT.
    - 000000 with Funct 000000: nop, go to FETCH.
    - 000000 otherwise: EXEC_R.
    - 100011 (lw) and 101011 (sw): ADDR.
    - 001000 (addi): EXEC_I.
    - 000100 (beq) and 000101 (bne): BRANCH; latch `isBne` = OpCode[0].
    - 000010 (j): JUMP.
    - Anything else: IllegalOp=1, then FETCH. The PC is already advanced, so the instruction is skipped.
- EXEC_R (3): ULAFonteA=1, ULAFonteB=00, ULAOp=10, ULASaidaCtrl=1. Next WB_R.
- WB_R (4): RegWrite=1, RegDst=1, MemParaReg=0. Next FETCH.
- ADDR (5):
  - Controls: ULAFonteA=1, ULAFonteB=10, ULAOp=00, ULASaidaCtrl=1.
  - Next: RD_WAIT for lw (load wcnt=MEM_WAIT), MEM_WR for sw.
- RD_WAIT (6): IouD=1. Same counting rule as FETCH. At wcnt=0 go to MDR_LOAD.
- MDR_LOAD (7): IouD=1, MDRCtrl=1. Next WB_LW.
- WB_LW (8): RegWrite=1, RegDst=0, MemParaReg=1. Next FETCH.
- MEM_WR (9): IouD=1, CtrMem=1 for exactly 1 cycle. Next FETCH.
- EXEC_I (10): ULAFonteA=1, ULAFonteB=10, ULAOp=00, ULASaidaCtrl=1. Next WB_I.
- WB_I (11): RegWrite=1, RegDst=0, MemParaReg=0. Next FETCH.
- BRANCH (12):
  - Controls: ULAFonteA=1, ULAFonteB=00, ULAOp=01, FontePC=01.
  - PCEsc = Zero XOR isBne.
  - Next: FETCH.
- JUMP (13): FontePC=10, PCEsc=1. Next FETCH.
- HALT (14): all controls 0, Halted=1. Stays in HALT until Reset.
- Unused state codes go to FETCH with all controls 0.

## Timing
- Reset: takes effect on the first rising edge with Reset=1 and overrides any transition. The state after reset is FETCH with wcnt=MEM_WAIT.
- Output values at reset: all outputs 0, `ULAOp`=11, `state`=0.
- Reset in the middle of MEM_WR deasserts CtrMem from the next cycle; no partial second write.
- Instruction fetch: IR_LOAD is entered exactly MEM_WAIT+1 cycles after FETCH is entered. MEM_WAIT=0 gives FETCH for 1 cycle.
- Load read: MDR_LOAD is entered MEM_WAIT+1 cycles after RD_WAIT is entered.
- Cycles per instruction, with W = MEM_WAIT:

| Instruction | Cycles |
|---|---|
| R-type, addi | W+5 |
| lw | 2W+7 |
| sw | W+5 |
| beq, bne, j | W+4 |
| nop, illegal | W+3 |

- Simultaneous events: `Zero` is sampled only in BRANCH. `IllegalOp` never overlaps any register write.

## Test plan
- MEM_WAIT=2, Reset held 2 cycles then released:
  - Required: `state` sequence 0,0,0,1,2.
  - Required: IREsc high only in cycle 3 after release.
  - Required: all outputs 0 and ULAOp=11 during reset.
- lw with MEM_WAIT=0 and with MEM_WAIT=3:
  - MEM_WAIT=0 required: 7 cycles total.
  - MEM_WAIT=3 required: 13 cycles total; IouD=1 for exactly 5 cycles.
  - Required: RegWrite=1 with MemParaReg=1 in one cycle only.
- beq and bne:
  - beq with Zero=1 -> PCEsc=1 with FontePC=01.
  - beq with Zero=0 -> PCEsc=0.
  - bne -> PCEsc is the inverse of beq for the same Zero.
- OpCode 111111 -> IllegalOp pulses 1 cycle, next state 0, no RegWrite and no CtrMem.
- break (OpCode 0, Funct 001101):
  - Required: Halted stays 1 for 50 cycles with all enables 0.
  - Required: Reset returns to state 0 on the next edge.
- sw with Reset asserted during MEM_WR -> CtrMem high for ≤1 cycle, `state`=0 on the next edge.

Source files
------------

// File: rtl/controlador_multiciclo.sv
// ============================================================================
// controlador_multiciclo
// ----------------------------------------------------------------------------
// Control unit for the multicycle MIPS datapath (PC, IR, A/B, ULASaida, MDR,
// register file, ALU muxes, unified memory). Moore FSM with a parametrised
// memory wait-state counter, internal branch resolution from the ALU Zero
// flag, and detection of unsupported opcodes.
//
// Parameters:
//   MEM_WAIT      extra memory read cycles (0..15); the address is held for
//                 MEM_WAIT+1 cycles before data is captured.
//
// Ports:
//   Clock         single clock, rising edge.
//   Reset         synchronous, active-high; forces FETCH.
//   OpCode        IR[31:26].
//   Funct         IR[5:0].
//   Zero          ALU zero flag (combinational from the datapath).
//   PCEsc         PC write enable, branch condition already folded in.
//   FontePC       PC source: 00 ALU, 01 ULASaida, 10 jump target.
//   CtrMem        1 = memory write, 0 = read.
//   IouD          memory address: 0 PC, 1 ULASaida.
//   IREsc, MDRCtrl, RegACtrl, RegBCtrl, ULASaidaCtrl
//                 register load enables.
//   RegWrite      register file write.
//   RegDst        destination register: 0 rt, 1 rd.
//   MemParaReg    write-back data: 0 ULASaida, 1 MDR.
//   ULAFonteA     ALU A: 0 PC, 1 A.
//   ULAFonteB     ALU B: 00 B, 01 4, 10 signext(imm), 11 signext(imm)<<2.
//   ULAOp         00 add, 01 sub, 10 by funct, 11 idle.
//   IllegalOp     one-cycle pulse in DECODE for an unsupported opcode.
//   Halted        high while in HALT.
//   state         current state code, for debug.
// ============================================================================
module controlador_multiciclo #(
    parameter int MEM_WAIT = 2
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [5:0] OpCode,
    input  logic [5:0] Funct,
    input  logic       Zero,
    output logic       PCEsc,
    output logic [1:0] FontePC,
    output logic       CtrMem,
    output logic       IouD,
    output logic       IREsc,
    output logic       MDRCtrl,
    output logic       RegACtrl,
    output logic       RegBCtrl,
    output logic       ULASaidaCtrl,
    output logic       RegWrite,
    output logic       RegDst,
    output logic       MemParaReg,
    output logic       ULAFonteA,
    output logic [1:0] ULAFonteB,
    output logic [1:0] ULAOp,
    output logic       IllegalOp,
    output logic       Halted,
    output logic [5:0] state
);

    typedef enum logic [5:0] {
        ST_FETCH    = 6'd0,
        ST_IR_LOAD  = 6'd1,
        ST_DECODE   = 6'd2,
        ST_EXEC_R   = 6'd3,
        ST_WB_R     = 6'd4,
        ST_ADDR     = 6'd5,
        ST_RD_WAIT  = 6'd6,
        ST_MDR_LOAD = 6'd7,
        ST_WB_LW    = 6'd8,
        ST_MEM_WR   = 6'd9,
        ST_EXEC_I   = 6'd10,
        ST_WB_I     = 6'd11,
        ST_BRANCH   = 6'd12,
        ST_JUMP     = 6'd13,
        ST_HALT     = 6'd14
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] FN_NOP   = 6'b000000;
    localparam logic [5:0] FN_BREAK = 6'b001101;

    // The wait counter is only 4 bits wide, so MEM_WAIT is used modulo 16.
    localparam logic [3:0] WAIT_INIT = 4'(MEM_WAIT);

    state_t     state_q, state_d;
    logic [3:0] wcnt_q, wcnt_d;
    logic       is_bne_q, is_bne_d;

    assign state = state_q;

    // State register, wait counter and latched branch type. Reset wins over
    // any pending transition and re-arms the counter for the first fetch.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q  <= ST_FETCH;
            wcnt_q   <= WAIT_INIT;
            is_bne_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            wcnt_q   <= wcnt_d;
            is_bne_q <= is_bne_d;
        end
    end

    // Next-state logic and Moore output decode. Every output defaults to its
    // idle value; each state only raises what it needs. The counter reloads
    // to WAIT_INIT whenever it is not counting, so any entry into FETCH or
    // RD_WAIT starts with a full wait.
    always_comb begin
        state_d      = state_q;
        wcnt_d       = WAIT_INIT;
        is_bne_d     = is_bne_q;

        PCEsc        = 1'b0;
        FontePC      = 2'b00;
        CtrMem       = 1'b0;
        IouD         = 1'b0;
        IREsc        = 1'b0;
        MDRCtrl      = 1'b0;
        RegACtrl     = 1'b0;
        RegBCtrl     = 1'b0;
        ULASaidaCtrl = 1'b0;
        RegWrite     = 1'b0;
        RegDst       = 1'b0;
        MemParaReg   = 1'b0;
        ULAFonteA    = 1'b0;
        ULAFonteB    = 2'b00;
        ULAOp        = 2'b11;
        IllegalOp    = 1'b0;
        Halted       = 1'b0;

        case (state_q)
            ST_FETCH: begin
                IouD   = 1'b0;
                CtrMem = 1'b0;
                if (wcnt_q != 4'd0) begin
                    wcnt_d = wcnt_q - 4'd1;
                end else begin
                    state_d = ST_IR_LOAD;
                end
            end

            ST_IR_LOAD: begin
                IREsc     = 1'b1;
                PCEsc     = 1'b1;
                FontePC   = 2'b00;
                ULAFonteA = 1'b0;
                ULAFonteB = 2'b01;
                ULAOp     = 2'b00;
                state_d   = ST_DECODE;
            end

            // Operands are latched and the branch target is precomputed
            // speculatively while the opcode is dispatched.
            ST_DECODE: begin
                RegACtrl     = 1'b1;
                RegBCtrl     = 1'b1;
                ULAFonteA    = 1'b0;
                ULAFonteB    = 2'b11;
                ULAOp        = 2'b00;
                ULASaidaCtrl = 1'b1;
                case (OpCode)
                    OP_RTYPE: begin
                        if (Funct == FN_BREAK) begin
                            state_d = ST_HALT;
                        end else if (Funct == FN_NOP) begin
                            state_d = ST_FETCH;
                        end else begin
                            state_d = ST_EXEC_R;
                        end
                    end
                    OP_LW, OP_SW: state_d = ST_ADDR;
                    OP_ADDI:      state_d = ST_EXEC_I;
                    OP_BEQ, OP_BNE: begin
                        state_d  = ST_BRANCH;
                        is_bne_d = OpCode[0];
                    end
                    OP_J:         state_d = ST_JUMP;
                    default: begin
                        // PC has already advanced, so the bad word is skipped.
                        IllegalOp = 1'b1;
                        state_d   = ST_FETCH;
                    end
                endcase
            end

            ST_EXEC_R: begin
                ULAFonteA    = 1'b1;
                ULAFonteB    = 2'b00;
                ULAOp        = 2'b10;
                ULASaidaCtrl = 1'b1;
                state_d      = ST_WB_R;
            end

            ST_WB_R: begin
                RegWrite   = 1'b1;
                RegDst     = 1'b1;
                MemParaReg = 1'b0;
                state_d    = ST_FETCH;
            end

            // IR is still held, so OpCode[3] separates sw (1) from lw (0).
            ST_ADDR: begin
                ULAFonteA    = 1'b1;
                ULAFonteB    = 2'b10;
                ULAOp        = 2'b00;
                ULASaidaCtrl = 1'b1;
                state_d      = OpCode[3] ? ST_MEM_WR : ST_RD_WAIT;
            end

            ST_RD_WAIT: begin
                IouD = 1'b1;
                if (wcnt_q != 4'd0) begin
                    wcnt_d = wcnt_q - 4'd1;
                end else begin
                    state_d = ST_MDR_LOAD;
                end
            end

            ST_MDR_LOAD: begin
                IouD    = 1'b1;
                MDRCtrl = 1'b1;
                state_d = ST_WB_LW;
            end

            ST_WB_LW: begin
                RegWrite   = 1'b1;
                RegDst     = 1'b0;
                MemParaReg = 1'b1;
                state_d    = ST_FETCH;
            end

            ST_MEM_WR: begin
                IouD    = 1'b1;
                CtrMem  = 1'b1;
                state_d = ST_FETCH;
            end

            ST_EXEC_I: begin
                ULAFonteA    = 1'b1;
                ULAFonteB    = 2'b10;
                ULAOp        = 2'b00;
                ULASaidaCtrl = 1'b1;
                state_d      = ST_WB_I;
            end

            ST_WB_I: begin
                RegWrite   = 1'b1;
                RegDst     = 1'b0;
                MemParaReg = 1'b0;
                state_d    = ST_FETCH;
            end

            // The ALU compares A and B; bne simply inverts the taken sense.
            ST_BRANCH: begin
                ULAFonteA = 1'b1;
                ULAFonteB = 2'b00;
                ULAOp     = 2'b01;
                FontePC   = 2'b01;
                PCEsc     = Zero ^ is_bne_q;
                state_d   = ST_FETCH;
            end

            ST_JUMP: begin
                FontePC = 2'b10;
                PCEsc   = 1'b1;
                state_d = ST_FETCH;
            end

            ST_HALT: begin
                Halted  = 1'b1;
                state_d = ST_HALT;
            end

            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

endmodule
